// File: rtl/jk_drv_pkg.sv
// Shared types and helpers for the JK flip-flop bank driver.
//   drv_state_e : controller states (StRecover only reachable with FORCE_RECOVERY_EN)
//   JK_HOLD     : J/K pair that leaves a JK flop unchanged
//   jk_excite   : JK excitation for one bit, q -> q_next, returned as {j, k}
package jk_drv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StExcite,
    StStrobe,
    StSettle,
    StCheck,
    StRecover
  } drv_state_e;

  localparam logic [1:0] JK_HOLD = 2'b00;

  // Don't-care half of each excitation entry resolves to 0, so J=K=1 (toggle) is never produced.
  function automatic logic [1:0] jk_excite(input logic q, input logic q_next);
    logic [1:0] jk;
    jk = JK_HOLD;
    if (!q && q_next) jk[1] = 1'b1;
    if (q && !q_next) jk[0] = 1'b1;
    return jk;
  endfunction

endpackage

// File: rtl/jk_excite_cell.sv
// Per-bit JK excitation, purely combinational.
//   q      : present flop state (feedback)
//   q_next : wanted flop state
//   j, k   : JK drive that moves q to q_next on the next flop clock
module jk_excite_cell
  import jk_drv_pkg::*;
(
  input  logic q,
  input  logic q_next,
  output logic j,
  output logic k
);

  logic [1:0] jk;

  assign jk = jk_excite(q, q_next);
  assign j  = jk[1];
  assign k  = jk[0];

endmodule

// File: rtl/jk_bank_driver.sv
// Controller that steers a bank of WIDTH external JK flip-flops to a requested word.
// A target is accepted in idle, J/K are set from the excitation table, one clock-enable
// strobe is issued, the bank is given SETTLE cycles, then Q is compared with the target.
// Mismatches are re-strobed up to MAX_RETRY times before an error pulse.
//
// Optional feature: define FORCE_RECOVERY_EN to add a recovery pass that forces the bank
// through its preset/clear pins after retries run out, followed by one final check.
// Without it, pr_n/clr_n are tied high.
//
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   tgt_data/valid/ready : target word handshake (ready only in idle)
//   q_fb               : Q feedback from the bank
//   j_out, k_out       : J/K drive
//   pr_n, clr_n        : active-low preset/clear drive
//   ff_ce              : one-cycle clock enable to the bank
//   done, error        : one-cycle result pulses
module jk_bank_driver
  import jk_drv_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic [WIDTH-1:0] pr_n,
  output logic [WIDTH-1:0] clr_n,
  output logic             ff_ce,
  output logic             done,
  output logic             error
);

  localparam int unsigned RetryW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned SettleW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  localparam logic [RetryW-1:0]  MaxRetry   = RetryW'(MAX_RETRY);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE - 1);

  drv_state_e         state_q;
  logic [WIDTH-1:0]   tgt_q;
  logic [WIDTH-1:0]   j_q, k_q;
  logic               ff_ce_q, done_q, error_q;
  logic [RetryW-1:0]  retry_q;
  logic [SettleW-1:0] settle_q;
  logic [WIDTH-1:0]   exc_j, exc_k;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_excite_cell u_cell (
      .q      (q_fb[i]),
      .q_next (tgt_q[i]),
      .j      (exc_j[i]),
      .k      (exc_k[i])
    );
  end

`ifdef FORCE_RECOVERY_EN
  logic [WIDTH-1:0] pr_n_q, clr_n_q;
  logic             recov_phase_q;  // 0: pins forcing, 1: pins released
  logic             recov_done_q;   // recovery already used for this target
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      tgt_q    <= '0;
      j_q      <= '0;
      k_q      <= '0;
      ff_ce_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      retry_q  <= '0;
      settle_q <= '0;
`ifdef FORCE_RECOVERY_EN
      pr_n_q        <= '1;
      clr_n_q       <= '1;
      recov_phase_q <= 1'b0;
      recov_done_q  <= 1'b0;
`endif
    end else begin
      ff_ce_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (tgt_valid) begin
            tgt_q   <= tgt_data;
            retry_q <= '0;
`ifdef FORCE_RECOVERY_EN
            recov_done_q <= 1'b0;
`endif
            state_q <= StExcite;
          end
        end
        StExcite: begin
          j_q     <= exc_j;
          k_q     <= exc_k;
          ff_ce_q <= 1'b1;
          state_q <= StStrobe;
        end
        StStrobe: begin
          // J/K held through the strobe cycle, back to hold afterwards
          j_q      <= '0;
          k_q      <= '0;
          settle_q <= '0;
          state_q  <= StSettle;
        end
        StSettle: begin
          if (settle_q == SettleLast) state_q  <= StCheck;
          else                        settle_q <= settle_q + 1'b1;
        end
        StCheck: begin
          if (q_fb == tgt_q) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (retry_q < MaxRetry) begin
            retry_q <= retry_q + 1'b1;
            state_q <= StExcite;
          end else begin
`ifdef FORCE_RECOVERY_EN
            if (!recov_done_q) begin
              // Complementary pair per bit, so preset and clear are never low together
              pr_n_q        <= ~tgt_q;
              clr_n_q       <= tgt_q;
              recov_phase_q <= 1'b0;
              state_q       <= StRecover;
            end else begin
              error_q <= 1'b1;
              state_q <= StIdle;
            end
`else
            error_q <= 1'b1;
            state_q <= StIdle;
`endif
          end
        end
`ifdef FORCE_RECOVERY_EN
        StRecover: begin
          if (!recov_phase_q) begin
            pr_n_q        <= '1;
            clr_n_q       <= '1;
            recov_phase_q <= 1'b1;
          end else begin
            recov_done_q <= 1'b1;
            state_q      <= StCheck;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tgt_ready = (state_q == StIdle);
  assign j_out     = j_q;
  assign k_out     = k_q;
  assign ff_ce     = ff_ce_q;
  assign done      = done_q;
  assign error     = error_q;

`ifdef FORCE_RECOVERY_EN
  assign pr_n  = pr_n_q;
  assign clr_n = clr_n_q;
`else
  assign pr_n  = '1;
  assign clr_n = '1;
`endif

endmodule
